// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared FSM state type, address default and quarter counts
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BIT,
    ACK,
    STOP,
    DONE
  } state_t;

  localparam logic [6:0] I2C_ADR_DEFAULT = 7'h27;

  localparam int Q_START = 2;
  localparam int Q_BIT   = 4;
  localparam int Q_STOP  = 3;

  // Byte 0 is the address byte, then command, then data MSB first.
  function automatic logic [7:0] pick_byte(input logic [1:0]  idx,
                                           input logic [7:0]  adr_byte,
                                           input logic [7:0]  cmd,
                                           input logic [15:0] dat);
    case (idx)
      2'd0:    return adr_byte;
      2'd1:    return cmd;
      2'd2:    return dat[15:8];
      default: return dat[7:0];
    endcase
  endfunction

endpackage

// File: rtl/i2c_master_tx_if.sv
// rtl/i2c_master_tx_if.sv - request/status bundle between a requester and i2c_master_tx
interface i2c_master_tx_if;

  logic        start;
  logic [7:0]  command;
  logic [15:0] data;
  logic        busy;
  logic        done;
  logic        nack_err;

  modport master (output start, command, data, input busy, done, nack_err);
  modport slave  (input start, command, data, output busy, done, nack_err);

endinterface

// File: rtl/i2c_qtick.sv
// rtl/i2c_qtick.sv - SCL quarter-period tick divider with synchronous clear
module i2c_qtick #(
  parameter int CLK_DIV = 125
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_master_tx.sv
// rtl/i2c_master_tx.sv - write-only I2C master: address, command and two data bytes
module i2c_master_tx
  import i2c_pkg::*;
#(
  parameter logic [6:0] I2C_ADR = I2C_ADR_DEFAULT,
  parameter int         CLK_DIV = 125
) (
  input  logic             clk,
  input  logic             rst_n,
  i2c_master_tx_if.slave   ctrl,
  output wire              SCL,
  inout  wire              SDA
);

  state_t      state, state_nxt;
  logic [1:0]  q, q_nxt;
  logic [2:0]  bit_cnt, bit_nxt;
  logic [1:0]  byte_cnt, byte_nxt;
  logic [7:0]  cmd_q;
  logic [15:0] data_q;
  logic        nack_q;
  logic        tick;
  logic        accept;
  logic        ack_sample;
  logic        sda_in;
  logic        tx_bit;
  logic        scl_low, sda_low;
  logic [7:0]  cur_byte;

  assign accept     = (state == IDLE) && ctrl.start;
  assign ack_sample = (state == ACK) && (q == 2'd2) && tick;
  assign cur_byte   = pick_byte(byte_cnt, {I2C_ADR, 1'b0}, cmd_q, data_q);
  assign tx_bit     = cur_byte[bit_cnt];

  i2c_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      q        <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      cmd_q    <= '0;
      data_q   <= '0;
      nack_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      q        <= q_nxt;
      bit_cnt  <= bit_nxt;
      byte_cnt <= byte_nxt;
      if (accept) begin
        cmd_q  <= ctrl.command;
        data_q <= ctrl.data;
        nack_q <= 1'b0;
      end else if (ack_sample && sda_in) begin
        nack_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    bit_nxt   = bit_cnt;
    byte_nxt  = byte_cnt;
    scl_low   = 1'b0;
    sda_low   = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl.start) begin
          state_nxt = START;
          q_nxt     = '0;
        end
      end
      START: begin
        sda_low = (q == 2'd1);
        if (tick) begin
          if (q == 2'(Q_START - 1)) begin
            state_nxt = BIT;
            q_nxt     = '0;
            bit_nxt   = 3'd7;
            byte_nxt  = 2'd0;
          end else begin
            q_nxt = q + 2'd1;
          end
        end
      end
      BIT: begin
        scl_low = (q < 2'd2);
        sda_low = !tx_bit;
        if (tick) begin
          if (q == 2'(Q_BIT - 1)) begin
            q_nxt = '0;
            if (bit_cnt == 3'd0) state_nxt = ACK;
            else                 bit_nxt   = bit_cnt - 3'd1;
          end else begin
            q_nxt = q + 2'd1;
          end
        end
      end
      ACK: begin
        scl_low = (q < 2'd2);
        if (tick) begin
          if (q == 2'(Q_BIT - 1)) begin
            q_nxt = '0;
            // nack_q was updated at the end of q2, so it already reflects this slot
            if (nack_q || byte_cnt == 2'd3) begin
              state_nxt = STOP;
            end else begin
              state_nxt = BIT;
              bit_nxt   = 3'd7;
              byte_nxt  = byte_cnt + 2'd1;
            end
          end else begin
            q_nxt = q + 2'd1;
          end
        end
      end
      STOP: begin
        scl_low = (q == 2'd0);
        sda_low = (q < 2'd2);
        if (tick) begin
          if (q == 2'(Q_STOP - 1)) begin
            state_nxt = DONE;
            q_nxt     = '0;
          end else begin
            q_nxt = q + 2'd1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign ctrl.busy     = (state != IDLE);
  assign ctrl.done     = (state == DONE);
  assign ctrl.nack_err = nack_q;

  assign SCL    = scl_low ? 1'b0 : 1'bz;
  assign SDA    = sda_low ? 1'b0 : 1'bz;
  assign sda_in = SDA;

endmodule

// File: tb/tb_i2c_master_tx.sv
// tb/tb_i2c_master_tx.sv - self-checking bench for i2c_master_tx with bus monitor and ACK/NACK slave
module tb_i2c_master_tx;

  localparam int         CLK_DIV  = 4;
  localparam logic [7:0] ADR_BYTE = 8'h4E;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2c_master_tx_if ctrl ();
  wire  scl_bus;
  wire  sda_bus;
  logic ack_drive = 1'b0;

  pullup (scl_bus);
  pullup (sda_bus);
  assign sda_bus = ack_drive ? 1'b0 : 1'bz;

  i2c_master_tx #(.I2C_ADR(7'h27), .CLK_DIV(CLK_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (ctrl),
    .SCL   (scl_bus),
    .SDA   (sda_bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Bus monitor and slave: decodes START/STOP, collects bytes and acks, drives ACK per nack_mask
  logic [7:0] mon_bytes[$];
  logic       mon_acks[$];
  int         mon_stops  = 0;
  int         proto_err  = 0;
  int         bitpos     = 0;
  int         byte_idx   = 0;
  logic       in_frame   = 1'b0;
  logic [7:0] sh         = '0;
  logic       p_scl      = 1'b1;
  logic       p_sda      = 1'b1;
  logic [3:0] nack_mask  = 4'h0;

  always @(negedge clk) begin
    logic s, d;
    s = scl_bus;
    d = sda_bus;
    if (!rst_n) begin
      in_frame  = 1'b0;
      bitpos    = 0;
      byte_idx  = 0;
      ack_drive = 1'b0;
    end else if (p_scl && s && (d !== p_sda)) begin
      if (!d) begin
        if (in_frame) begin
          proto_err++;
          $display("protocol: SDA fell with SCL high inside a frame at %0t", $time);
        end
        in_frame = 1'b1;
        bitpos   = 0;
        byte_idx = 0;
      end else begin
        if (!in_frame) begin
          proto_err++;
          $display("protocol: SDA rose with SCL high outside a frame at %0t", $time);
        end
        in_frame = 1'b0;
        mon_stops++;
      end
    end else if (in_frame && !p_scl && s) begin
      if (bitpos < 8) begin
        sh = {sh[6:0], d};
        bitpos++;
      end else begin
        mon_bytes.push_back(sh);
        mon_acks.push_back(d);
        bitpos = 0;
        byte_idx++;
      end
    end else if (in_frame && p_scl && !s) begin
      ack_drive = (bitpos == 8) && (byte_idx < 4) && !nack_mask[byte_idx];
    end
    p_scl = s;
    p_sda = d;
  end

  // Reference model: the bytes on the wire, how many get clocked, and the total length
  function automatic logic [7:0] model_byte(input int i, input logic [7:0] cmd, input logic [15:0] dat);
    logic [31:0] word;
    word = {ADR_BYTE, cmd, dat};
    return word[31 - 8*i -: 8];
  endfunction

  function automatic int model_nbytes(input logic [3:0] mask);
    for (int i = 0; i < 4; i++) if (mask[i]) return i + 1;
    return 4;
  endfunction

  function automatic int model_cycles(input int n);
    return (2 + 36 * n + 3) * CLK_DIV;
  endfunction

  task automatic run_txn(input logic [7:0] cmd, input logic [15:0] dat, input logic [3:0] mask,
                         input int mid_at, output int cycles);
    @(negedge clk);
    #1;
    mon_bytes.delete();
    mon_acks.delete();
    mon_stops     = 0;
    nack_mask     = mask;
    ctrl.start    = 1'b1;
    ctrl.command  = cmd;
    ctrl.data     = dat;
    @(negedge clk);
    ctrl.start = 1'b0;
    check("busy_after_accept", ctrl.busy, 1'b1);
    cycles = 0;
    while (cycles < 2000) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (ctrl.done) break;
      if (mid_at > 0 && cycles == mid_at) begin
        ctrl.start   = 1'b1;
        ctrl.command = ~cmd;
        ctrl.data    = ~dat;
      end else begin
        ctrl.start   = 1'b0;
        ctrl.command = cmd;
        ctrl.data    = dat;
      end
    end
    ctrl.start = 1'b0;
  endtask

  task automatic check_txn(input string tag, input logic [7:0] cmd, input logic [15:0] dat,
                           input int exp_n, input logic exp_nack, input int exp_cycles, input int cycles);
    check($sformatf("%s cycles", tag), cycles, exp_cycles);
    check($sformatf("%s nack_err", tag), ctrl.nack_err, exp_nack);
    check($sformatf("%s busy_in_done", tag), ctrl.busy, 1'b1);
    check($sformatf("%s nbytes", tag), mon_bytes.size(), exp_n);
    for (int i = 0; i < exp_n && i < mon_bytes.size(); i++)
      check($sformatf("%s byte%0d", tag, i), mon_bytes[i], model_byte(i, cmd, dat));
    check($sformatf("%s stops", tag), mon_stops, 1);
    @(negedge clk);
    check($sformatf("%s done_pulse", tag), ctrl.done, 1'b0);
    check($sformatf("%s busy_after", tag), ctrl.busy, 1'b0);
    check($sformatf("%s nack_hold", tag), ctrl.nack_err, exp_nack);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] dat;
    logic [3:0]  mask;
    int          exp_n;
    logic        exp_nack;
    int          exp_cycles;
  } vec_t;

  vec_t vt[6];

  initial begin
    int   cyc;
    logic found;
    logic [7:0]  rc;
    logic [15:0] rd;
    logic [3:0]  rm;

    vt[0] = '{8'hA5, 16'h1234, 4'b0000, 4, 1'b0, 596};
    vt[1] = '{8'h3C, 16'hBEEF, 4'b1111, 1, 1'b1, 164};
    vt[2] = '{8'h5A, 16'h0F0F, 4'b0100, 3, 1'b1, 452};
    vt[3] = '{8'hA5, 16'h1234, 4'b0000, 4, 1'b0, 596};
    vt[4] = '{8'h00, 16'hFFFF, 4'b1000, 4, 1'b1, 596};
    vt[5] = '{8'hFF, 16'h0000, 4'b0010, 2, 1'b1, 308};

    ctrl.start   = 1'b0;
    ctrl.command = '0;
    ctrl.data    = '0;

    repeat (3) @(negedge clk);
    check("reset busy", ctrl.busy, 1'b0);
    check("reset done", ctrl.done, 1'b0);
    check("reset nack_err", ctrl.nack_err, 1'b0);
    check("reset SCL", scl_bus, 1'b1);
    check("reset SDA", sda_bus, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_txn(vt[i].cmd, vt[i].dat, vt[i].mask, 0, cyc);
      check_txn($sformatf("vec%0d", i), vt[i].cmd, vt[i].dat, vt[i].exp_n, vt[i].exp_nack,
                vt[i].exp_cycles, cyc);
    end

    // Idle reset clears a sticky nack_err
    check("nack_err before reset", ctrl.nack_err, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("nack_err after reset", ctrl.nack_err, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // start pulsed mid-transaction with other operands must be ignored
    run_txn(8'hA5, 16'h1234, 4'b0000, 100, cyc);
    check_txn("midstart", 8'hA5, 16'h1234, 4, 1'b0, 596, cyc);

    // Reset during the third bit of the command byte
    @(negedge clk);
    #1;
    nack_mask    = 4'h0;
    ctrl.start   = 1'b1;
    ctrl.command = 8'hA5;
    ctrl.data    = 16'h1234;
    @(negedge clk);
    ctrl.start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 1000 && !found; k++) begin
      @(posedge clk);
      if (byte_idx == 1 && bitpos == 2 && p_scl == 1'b0) found = 1'b1;
    end
    check("reached cmd bit 3", found, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("midreset SCL", scl_bus, 1'b1);
    check("midreset SDA", sda_bus, 1'b1);
    check("midreset busy", ctrl.busy, 1'b0);
    check("midreset done", ctrl.done, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_txn(8'hC3, 16'h5AA5, 4'b0000, 0, cyc);
    check_txn("after_reset", 8'hC3, 16'h5AA5, 4, 1'b0, 596, cyc);

    // Randomised transactions against the model
    for (int r = 0; r < 6; r++) begin
      rc = 8'($urandom);
      rd = 16'($urandom);
      rm = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      run_txn(rc, rd, rm, 0, cyc);
      check_txn($sformatf("rand%0d", r), rc, rd, model_nbytes(rm), (rm != 4'h0),
                model_cycles(model_nbytes(rm)), cyc);
    end

    check("protocol violations", proto_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_master_tx.md
I2C_MASTER_TX -- requirements
Module: i2c_master_tx

Interface
REQ-001 Parameter I2C_ADR, default 7'h27, meaning: 7-bit target slave address.
REQ-002 Parameter CLK_DIV, default 125, meaning: clk cycles per SCL quarter-period (min 2).
REQ-003 clk  input  1  single system clock, all logic rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request pulse; begins one write transaction.
REQ-006 command  input  8  first payload byte.
REQ-007 data  input  16  second/third payload bytes, MSB first.
REQ-008 busy  output  1  high while a transaction is in progress.
REQ-009 done  output  1  one-cycle pulse at transaction end (success or abort).
REQ-010 nack_err  output  1  high if the last transaction saw a NACK; valid with done.
REQ-011 SCL  output  1  open-drain: drives 0 or high-Z, never drives 1.
REQ-012 SDA  inout  1  open-drain: drives 0 or high-Z, never drives 1.

Function
REQ-013 Transaction order: START, byte {I2C_ADR,1'b0}, ACK, command, ACK, data[15:8], ACK, data[7:0], ACK, STOP.
REQ-014 Timing base: quarter tick every CLK_DIV clk cycles from an internal counter; the counter resets to 0 when a start is accepted.
REQ-015 FSM states: IDLE, START, BIT, ACK, STOP, DONE.
REQ-016 IDLE: SCL and SDA released; start=1 with busy=0 is accepted; command/data latched that cycle; busy=1 from the next cycle.
REQ-017 start while busy=1 is ignored; latched operands do not change.
REQ-018 START (2 quarters): q0 SCL=Z, SDA=Z; q1 SCL=Z, SDA=0.
REQ-019 BIT (4 quarters per bit, MSB first): q0 SCL=0, SDA=bit value; q1 SCL=0; q2 SCL=Z; q3 SCL=Z; SDA stable through q1-q3.
REQ-020 ACK (4 quarters): SDA released; SCL as in BIT; SDA sampled on the last clk of q2; 0 = ACK, 1 = NACK.
REQ-021 Bit counter 3 bits, 7 down to 0; byte counter 2 bits, 0 to 3; after ACK of byte 3, go to STOP.
REQ-022 NACK on any byte: skip remaining bytes, go to STOP, set nack_err=1.
REQ-023 STOP (3 quarters): q0 SCL=0, SDA=0; q1 SCL=Z, SDA=0; q2 SCL=Z, SDA=Z.
REQ-024 DONE: one clk, done=1, busy=0 in the following cycle; back to IDLE.
REQ-025 Successful transaction: exactly 149 quarters (2+36*4+3) from accept to DONE.
REQ-026 nack_err cleared on next accepted start; holds value otherwise.
REQ-027 No clock stretching and no arbitration; SCL input level is not monitored.
REQ-028 SDA changes only while SCL is low, except START/STOP edges.

Reset
REQ-029 rst_n=0 immediately releases SCL and SDA (high-Z), forces IDLE, busy=0, done=0, nack_err=0, and clears all counters, including mid-transaction (no STOP issued).
REQ-030 After rst_n deasserts, the block accepts start on the first clk edge.

Structure
REQ-031 Shared package i2c_pkg: FSM state enum, I2C_ADR default 7'h27, quarter counts for START (2), BIT (4), and STOP (3).
REQ-032 One sub-module i2c_qtick: CLK_DIV quarter-tick divider with sync clear.
REQ-033 Open-drain tristates are coded only at the top level of i2c_master_tx.

Verification
REQ-034 Verification scenario: CLK_DIV=4, slave model ACKs all; start with command=8'hA5, data=16'h1234 -> bytes 4E,A5,12,34 on bus; done after 596 cycles; nack_err=0.
REQ-035 Verification scenario: no slave (SDA pulled up) -> NACK on address byte, STOP issued, done with nack_err=1, and no further bytes clocked.
REQ-036 Verification scenario: slave NACKs byte 2 (data[15:8]) -> STOP follows that ACK slot; nack_err=1; next good transaction clears nack_err.
REQ-037 Verification scenario: start pulsed mid-transaction with different operands -> ignored; bus carries original bytes.
REQ-038 Verification scenario: rst_n low during the 3rd bit of command -> SCL/SDA high-Z the same cycle, busy=0, and a new start after release completes normally.
REQ-039 Verification scenario: protocol checker over all runs -> SDA never changes while SCL high except START/STOP, and SCL/SDA never driven 1.
